// File: rtl/accel_job_driver.sv
// accel_job_driver
//   Initiator side of an accelerator start/done handshake. Work words arrive on a
//   valid/ready stream and are buffered in a small FIFO. Each word is issued to the
//   accelerator with a one-cycle start pulse. The driver then waits for a rising edge
//   of done, captures the result and offers it on a valid/ready result stream. A
//   watchdog stops the driver in a sticky error state if done never arrives.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   in_valid_i    host word valid
//   in_data_i     host work word
//   in_ready_o    driver can accept a word
//   acc_start_o   one-cycle start pulse to the accelerator
//   acc_data_o    word presented to the accelerator (held until the next pop)
//   acc_result_i  accelerator result
//   acc_done_i    accelerator done level
//   res_valid_o   captured result valid
//   res_data_o    captured result
//   res_ready_i   result consumer ready
//   busy_o        job in flight or words pending
//   timeout_o     sticky watchdog error
//   jobs_o        count of results consumed by the host
module accel_job_driver #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned JOB_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              acc_start_o,
    output logic [DATA_W-1:0] acc_data_o,
    input  logic [DATA_W-1:0] acc_result_i,
    input  logic              acc_done_i,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_data_o,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [JOB_W-1:0]  jobs_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StErr} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [DATA_W-1:0] acc_data_q, acc_data_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [JOB_W-1:0]  jobs_q, jobs_d;
    logic              done_q;
    logic              done_rise;
    logic              push;
    logic              pop;

    // A done level left high by the previous job must fall and rise again.
    assign done_rise = acc_done_i & ~done_q;

    // Readiness comes from the registered count only; a same-cycle pop never frees a slot.
    assign in_ready_o = (count_q < CntW'(FIFO_DEPTH)) && (state_q != StErr);
    assign push       = in_valid_i && in_ready_o;

    always_comb begin
        state_d    = state_q;
        acc_data_d = acc_data_q;
        res_data_d = res_data_q;
        timer_d    = timer_q;
        jobs_d     = jobs_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    acc_data_d = mem_q[rd_ptr_q];
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // A rising done beats an expiring timer in the same cycle.
                if (done_rise) begin
                    res_data_d = acc_result_i;
                    state_d    = StHold;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                    if (timer_d == TmrW'(TIMEOUT)) begin
                        state_d = StErr;
                    end
                end
            end
            StHold: begin
                if (res_ready_i) begin
                    jobs_d  = jobs_q + JOB_W'(1);
                    state_d = StIdle;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            acc_data_q <= '0;
            res_data_q <= '0;
            jobs_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            acc_data_q <= acc_data_d;
            res_data_q <= res_data_d;
            jobs_q     <= jobs_d;
            done_q     <= acc_done_i;
        end
    end

    // Storage needs no reset: the cleared count makes stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign acc_start_o = (state_q == StIssue);
    assign acc_data_o  = acc_data_q;
    assign res_valid_o = (state_q == StHold);
    assign res_data_o  = res_data_q;
    assign busy_o      = (state_q != StIdle) || (count_q != '0);
    assign timeout_o   = (state_q == StErr);
    assign jobs_o      = jobs_q;

endmodule

// File: tb/tb_accel_job_driver.sv
// Bench for accel_job_driver: an accelerator stand-in answers each start with the
// running count of even-valued bytes seen since reset; a queue-based reference
// predicts issued words and returned results from the pushed words.
module tb_accel_job_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        acc_start;
    logic [31:0] acc_data;
    logic [31:0] acc_result = '0;
    logic        acc_done = 1'b0;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        timeout;
    logic [15:0] jobs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accel_job_driver #(
        .DATA_W    (32),
        .FIFO_DEPTH(4),
        .TIMEOUT   (255),
        .JOB_W     (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .acc_start_o (acc_start),
        .acc_data_o  (acc_data),
        .acc_result_i(acc_result),
        .acc_done_i  (acc_done),
        .res_valid_o (res_valid),
        .res_data_o  (res_data),
        .res_ready_i (res_ready),
        .busy_o      (busy),
        .timeout_o   (timeout),
        .jobs_o      (jobs)
    );

    function automatic int even_bytes(input logic [31:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (w[8*i] == 1'b0) n++;
        end
        return n;
    endfunction

    // Accelerator stand-in.
    int          acc_lat = 3;
    bit          never_done = 1'b0;
    bit          stale_hold = 1'b0;
    int          model_accum = 0;
    int          model_delay = 0;
    bit          model_pending = 1'b0;
    logic [31:0] model_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            acc_done      <= 1'b0;
            acc_result    <= '0;
            model_accum   <= 0;
            model_pending <= 1'b0;
            model_delay   <= 0;
        end else if (acc_start) begin
            model_accum   <= model_accum + even_bytes(acc_data);
            model_res     <= 32'(model_accum + even_bytes(acc_data));
            model_pending <= 1'b1;
            model_delay   <= acc_lat;
            if (!stale_hold) acc_done <= 1'b0;
        end else if (model_pending) begin
            if (model_delay <= 1) begin
                model_pending <= 1'b0;
                if (!never_done) begin
                    acc_done   <= 1'b1;
                    acc_result <= model_res;
                end
            end else begin
                model_delay <= model_delay - 1;
                if (stale_hold && model_delay == 3) acc_done <= 1'b0;
            end
        end else if (!stale_hold) begin
            acc_done <= 1'b0;
        end
    end

    logic [31:0] start_q[$];
    always @(posedge clk) begin
        if (!rst && acc_start) start_q.push_back(acc_data);
    end

    // Reference model state.
    logic [31:0] push_q[$];
    logic [31:0] sent_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          accum_ref = 0;
    bit          saw_full = 1'b0;

    task automatic ref_push(input logic [31:0] w);
        push_q.push_back(w);
        sent_q.push_back(w);
        accum_ref += even_bytes(w);
        exp_q.push_back(32'(accum_ref));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_q.delete();
        push_q.delete();
        sent_q.delete();
        exp_q.delete();
        got_q.delete();
        accum_ref = 0;
        saw_full = 1'b0;
        #1;
    endtask

    // Drive one cycle at the falling edge and record handshakes that the next rising edge takes.
    task automatic step_drive(input int ready_pct);
        @(negedge clk);
        in_valid = (push_q.size() > 0);
        if (in_valid) in_data = push_q[0];
        res_ready = ($urandom_range(99) < ready_pct);
        #1;
        if (in_valid && !in_ready) saw_full = 1'b1;
        if (in_valid && in_ready) void'(push_q.pop_front());
        if (res_valid && res_ready) got_q.push_back(res_data);
    endtask

    task automatic run_stream(input int ready_pct, input int n, input int budget,
                              output bit expired);
        expired = 1'b1;
        for (int c = 0; c < budget; c++) begin
            step_drive(ready_pct);
            if (got_q.size() >= n && push_q.size() == 0) begin
                expired = 1'b0;
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        res_ready = 1'b0;
        #1;
    endtask

    task automatic cmp_streams(input string tag);
        logic [31:0] g;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_result_count: got %0d want %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_result[%0d]: got %h want %h", tag, i, g, exp_q[i]);
            end
        end
        checks++;
        if (start_q.size() != sent_q.size()) begin
            errors++;
            $display("FAIL %s_start_count: got %0d want %0d", tag, start_q.size(), sent_q.size());
        end
        for (int i = 0; i < sent_q.size(); i++) begin
            g = (i < start_q.size()) ? start_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (g !== sent_q[i]) begin
                errors++;
                $display("FAIL %s_issued[%0d]: got %h want %h", tag, i, g, sent_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL reset_acc_start: got %b want 0", acc_start); end
        checks++; if (acc_data !== 32'h0) begin errors++; $display("FAIL reset_acc_data: got %h want 0", acc_data); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if (jobs !== 16'd0) begin errors++; $display("FAIL reset_jobs: got %0d want 0", jobs); end
    endtask

    task automatic test_single();
        bit expired;
        do_reset();
        acc_lat = 3;
        ref_push(32'h0102_0304);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h0102_0304;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        void'(push_q.pop_front());
        #1;
        checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", acc_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        #1;
        checks++; if (acc_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", acc_start); end
        checks++; if (acc_data !== 32'h0102_0304) begin errors++; $display("FAIL single_acc_data: got %h want 01020304", acc_data); end
        @(negedge clk);
        #1;
        checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b want 0", acc_start); end
        run_stream(100, 1, 50, expired);
        checks++; if (expired) begin errors++; $display("FAIL single_budget: got expired want done"); end
        cmp_streams("single");
        checks++; if (jobs !== 16'd1) begin errors++; $display("FAIL single_jobs: got %0d want 1", jobs); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_valid_after: got %b want 0", res_valid); end
        checks++; if (acc_data !== 32'h0102_0304) begin errors++; $display("FAIL single_acc_data_hold: got %h want 01020304", acc_data); end
    endtask

    task automatic test_burst();
        bit expired;
        do_reset();
        acc_lat = 3;
        ref_push(32'h0102_0304);
        ref_push(32'h0506_0708);
        ref_push(32'h090A_0B0C);
        ref_push(32'h0204_0608);
        ref_push(32'h0103_0507);
        ref_push(32'h0000_0000);
        run_stream(100, 6, 400, expired);
        checks++; if (expired) begin errors++; $display("FAIL burst_budget: got expired want done"); end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL burst_backpressure: got %b want 1", saw_full); end
        cmp_streams("burst");
        checks++; if (jobs !== 16'd6) begin errors++; $display("FAIL burst_jobs: got %0d want 6", jobs); end
    endtask

    task automatic test_backpressure();
        bit          expired;
        bit          found;
        logic [31:0] held;
        do_reset();
        acc_lat = 3;
        ref_push(32'h0102_0304);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step_drive(0);
            if (res_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_first_result: got none want res_valid"); end
        held = res_data;
        checks++; if (held !== exp_q[0]) begin errors++; $display("FAIL bp_held_value: got %h want %h", held, exp_q[0]); end
        ref_push(32'h0506_0708);
        ref_push(32'h090A_0B0C);
        ref_push(32'h0204_0608);
        ref_push(32'h0103_0507);
        for (int c = 0; c < 10; c++) begin
            step_drive(0);
            checks++; if (res_data !== held) begin errors++; $display("FAIL bp_res_stable: got %h want %h", res_data, held); end
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid: got %b want 1", res_valid); end
            checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL bp_no_start: got %b want 0", acc_start); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_fifo_full: got in_ready %b want 0", in_ready); end
        checks++; if (push_q.size() != 0) begin errors++; $display("FAIL bp_all_pushed: got %0d left want 0", push_q.size()); end
        run_stream(100, 5, 300, expired);
        checks++; if (expired) begin errors++; $display("FAIL bp_budget: got expired want done"); end
        cmp_streams("bp");
        checks++; if (jobs !== 16'd5) begin errors++; $display("FAIL bp_jobs: got %0d want 5", jobs); end
    endtask

    task automatic test_timeout();
        bit found;
        int k;
        do_reset();
        never_done = 1'b1;
        ref_push(32'h0102_0304);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step_drive(100);
            if (acc_start) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL to_start: got none want start"); end
        in_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            k++;
            if (timeout) break;
        end
        // ERR is seen on the cycle after the 255th WAIT cycle.
        checks++; if (k != 256) begin errors++; $display("FAIL to_wait_cycles: got %0d want 256", k); end
        ref_push(32'h0506_0708);
        for (int c = 0; c < 5; c++) begin
            step_drive(100);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_in_ready: got %b want 0", in_ready); end
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL to_res_valid: got %b want 0", res_valid); end
            checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL to_acc_start: got %b want 0", acc_start); end
            checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout); end
        end
        never_done = 1'b0;
        do_reset();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_reset_timeout: got %b want 0", timeout); end
        checks++; if (acc_data !== 32'h0) begin errors++; $display("FAIL to_reset_acc_data: got %h want 0", acc_data); end
        checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL to_reset_res_data: got %h want 0", res_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL to_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_stale_done();
        bit expired;
        do_reset();
        stale_hold = 1'b1;
        acc_lat = 5;
        ref_push(32'h0102_0304);
        ref_push(32'h0204_0608);
        run_stream(100, 2, 200, expired);
        checks++; if (expired) begin errors++; $display("FAIL stale_budget: got expired want done"); end
        cmp_streams("stale");
        stale_hold = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit expired;
        do_reset();
        acc_lat = 3;
        ref_push(32'h0000_0011);
        run_stream(100, 1, 50, expired);
        checks++; if (jobs !== 16'd1) begin errors++; $display("FAIL mid_jobs_before: got %0d want 1", jobs); end
        acc_lat = 20;
        ref_push(32'h0102_0304);
        ref_push(32'h0506_0708);
        ref_push(32'h090A_0B0C);
        for (int c = 0; c < 40; c++) begin
            step_drive(100);
            if (push_q.size() == 0 && start_q.size() >= 2) break;
        end
        step_drive(100);
        step_drive(100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (jobs !== 16'd0) begin errors++; $display("FAIL mid_jobs: got %0d want 0", jobs); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_res_valid: got %b want 0", res_valid); end
        for (int c = 0; c < 10; c++) step_drive(100);
        checks++; if (start_q.size() != 0) begin errors++; $display("FAIL mid_no_start: got %0d starts want 0", start_q.size()); end
        acc_lat = 3;
        ref_push(32'h0204_0608);
        run_stream(100, 1, 50, expired);
        checks++; if (expired) begin errors++; $display("FAIL mid_budget: got expired want done"); end
        cmp_streams("mid");
    endtask

    task automatic test_random();
        bit expired;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            acc_lat = $urandom_range(1, 6);
            for (int i = 0; i < 24; i++) ref_push($urandom);
            run_stream(60, 24, 2000, expired);
            checks++; if (expired) begin errors++; $display("FAIL rand_budget: got expired want done"); end
            cmp_streams("rand");
            checks++; if (jobs !== 16'd24) begin errors++; $display("FAIL rand_jobs: got %0d want 24", jobs); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_stale_done();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
